header_adj_mp: RTL and testbench

- Parametrised successor of the card-to-host routing-header adjuster on the final XDMA stream.
- Discards all incoming routing headers and emits a fixed count of dummy headers, then the length word, then the payload.
- The dummy-header count is selectable per packet at runtime.
- Generalised data width; TLAST is generated from the length word; length/TLAST mismatches are detected and recovered from; accepted packets are counted.

---
 rtl/header_adj_mp.sv | 181 ++++++++++++++++++
 tb/tb_header_adj_mp.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_adj_mp.sv
// Card-to-host routing-header adjuster. It drops incoming routing headers and emits N dummy
// headers and the length word, then forwards the payload with a TLAST derived from the length.
module header_adj_mp #(
  parameter int                DATA_W     = 64,
  parameter int                LEN_W      = 32,
  parameter int                HEADER_MAX = 10,
  parameter logic [7:0]        HDR_TAG    = 8'h01,
  parameter logic [DATA_W-1:0] DUMMY_HDR  = {8'h01, {(DATA_W-8){1'b0}}}
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [15:0]       CFG_HDR_N,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic [31:0]       PKT_CNT,
  output logic              ERR_LEN
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LEN, S_PAY, S_DRAIN} state_e;

  localparam logic [15:0] HDR_DEF = 16'(HEADER_MAX);

  state_e              state_q, state_d;
  logic [15:0]         hdr_cnt_q, hdr_cnt_d;
  logic [LEN_W-1:0]    len_r_q, len_r_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                len_ok_q, len_ok_d;
  logic                reg_valid_q, reg_valid_d;
  logic                reg_last_q, reg_last_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic                in_done_q, in_done_d;
  logic                drain_pend_q, drain_pend_d;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic                err_q, err_d;
  logic                live_q;
  logic [15:0]         hdr_n;
  logic                parser_on;

  assign PKT_CNT = pkt_cnt_q;
  assign ERR_LEN = err_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    len_r_d       = len_r_q;
    rem_d         = rem_q;
    len_ok_d      = len_ok_q;
    reg_valid_d   = reg_valid_q;
    reg_last_d    = reg_last_q;
    reg_data_d    = reg_data_q;
    in_done_d     = in_done_q;
    drain_pend_d  = drain_pend_q;
    pkt_cnt_d     = pkt_cnt_q;
    err_d         = err_q;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = '0;
    hdr_n         = (CFG_HDR_N == 16'd0) ? HDR_DEF : CFG_HDR_N;
    parser_on     = (state_q inside {S_IDLE, S_HDR, S_LEN}) && !len_ok_q;

    // Ready stays low for the first cycle after reset, so every output reads 0 there.
    if (parser_on) S_AXIS_TREADY = live_q;

    case (state_q)
      S_IDLE: begin
        if (S_AXIS_TVALID) begin
          hdr_cnt_d = hdr_n;
          state_d   = (hdr_n == 16'd0) ? S_LEN : S_HDR;
        end
      end
      S_HDR: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = DUMMY_HDR;
        if (M_AXIS_TREADY) begin
          hdr_cnt_d = hdr_cnt_q - 16'd1;
          if (hdr_cnt_q <= 16'd1) state_d = S_LEN;
        end
      end
      S_LEN: begin
        M_AXIS_TVALID = len_ok_q;
        M_AXIS_TDATA  = DATA_W'(len_r_q);
        M_AXIS_TLAST  = len_ok_q && (len_r_q == '0);
        if (len_ok_q && M_AXIS_TREADY) begin
          if (len_r_q == '0) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            len_ok_d  = 1'b0;
            state_d   = S_IDLE;
          end else begin
            rem_d        = len_r_q;
            in_done_d    = 1'b0;
            drain_pend_d = 1'b0;
            state_d      = S_PAY;
          end
        end
      end
      S_PAY: begin
        S_AXIS_TREADY = !in_done_q && (M_AXIS_TREADY || !reg_valid_q);
        M_AXIS_TVALID = reg_valid_q;
        M_AXIS_TDATA  = reg_data_q;
        M_AXIS_TLAST  = reg_last_q;
        if (reg_valid_q && M_AXIS_TREADY) begin
          reg_valid_d = 1'b0;
          if (reg_last_q) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            len_ok_d  = 1'b0;
            state_d   = drain_pend_q ? S_DRAIN : S_IDLE;
          end
        end
        // The terminal word is whichever comes first: length exhausted or input TLAST.
        if (S_AXIS_TVALID && S_AXIS_TREADY) begin
          reg_valid_d = 1'b1;
          reg_data_d  = S_AXIS_TDATA;
          rem_d       = rem_q - LEN_W'(1);
          reg_last_d  = (rem_q == LEN_W'(1)) || S_AXIS_TLAST;
          in_done_d   = reg_last_d;
          if (rem_q == LEN_W'(1) && !S_AXIS_TLAST) begin
            err_d        = 1'b1;
            drain_pend_d = 1'b1;
          end
          if (rem_q != LEN_W'(1) && S_AXIS_TLAST) err_d = 1'b1;
        end
      end
      S_DRAIN: begin
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && S_AXIS_TLAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (parser_on && S_AXIS_TVALID && S_AXIS_TREADY &&
        S_AXIS_TDATA[DATA_W-1 -: 8] != HDR_TAG) begin
      len_r_d  = S_AXIS_TDATA[LEN_W-1:0];
      len_ok_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      hdr_cnt_q    <= '0;
      len_r_q      <= '0;
      rem_q        <= '0;
      len_ok_q     <= 1'b0;
      reg_valid_q  <= 1'b0;
      reg_last_q   <= 1'b0;
      in_done_q    <= 1'b0;
      drain_pend_q <= 1'b0;
      pkt_cnt_q    <= '0;
      err_q        <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_cnt_q    <= hdr_cnt_d;
      len_r_q      <= len_r_d;
      rem_q        <= rem_d;
      len_ok_q     <= len_ok_d;
      reg_valid_q  <= reg_valid_d;
      reg_last_q   <= reg_last_d;
      in_done_q    <= in_done_d;
      drain_pend_q <= drain_pend_d;
      pkt_cnt_q    <= pkt_cnt_d;
      err_q        <= err_d;
      live_q       <= 1'b1;
    end
  end

  // NOTE: the payload data register is not reset; reg_valid_q alone says whether it holds a word.
  always_ff @(posedge CLK) begin
    reg_data_q <= reg_data_d;
  end

endmodule

// File: tb/tb_header_adj_mp.sv
// Randomised self-checking bench for header_adj_mp (DATA_W=128) against a packet-level model
// that derives the expected output stream from each packet's header count, length and payload.
module tb_header_adj_mp;

  localparam int DW = 128;
  localparam logic [DW-1:0] DUMMY = {8'h01, 120'h0};

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   cfg_hdr_n;
  logic          s_tvalid, s_tready, s_tlast;
  logic [DW-1:0] s_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [31:0]   pkt_cnt;
  logic          err_len;

  header_adj_mp #(.DATA_W(DW)) dut (
    .CLK(clk), .RST_N(rst_n), .CFG_HDR_N(cfg_hdr_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TLAST(s_tlast),
    .S_AXIS_TDATA(s_tdata),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready), .M_AXIS_TLAST(m_tlast),
    .M_AXIS_TDATA(m_tdata),
    .PKT_CNT(pkt_cnt), .ERR_LEN(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cnt_model = 0;
  bit err_model = 1'b0;
  bit mon_en = 1'b0;
  int ready_pct = 100;
  int cyc = 0;

  beat_t         exp_q[$];
  logic [DW-1:0] log_data[$];
  logic          log_last[$];
  int            log_cyc[$];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // Output sink readiness
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1 m_tready = ($urandom_range(99) < ready_pct);
    end
  end

  // Compare process: every cycle, scoreboard handshakes, stall stability, packet count
  initial begin
    bit            stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    beat_t         e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        check("pkt_cnt", DW'(pkt_cnt), DW'(cnt_model));
        if (stall_prev) begin
          check("stall_valid", DW'(m_tvalid), DW'(1));
          check("stall_data", m_tdata, stall_data);
          check("stall_last", DW'(m_tlast), DW'(stall_last));
        end
        if (m_tvalid && m_tready) begin
          log_data.push_back(m_tdata);
          log_last.push_back(m_tlast);
          log_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", m_tdata);
          end else begin
            e = exp_q.pop_front();
            check("out_data", m_tdata, e.data);
            check("out_last", DW'(m_tlast), DW'(e.last));
            if (e.last) cnt_model++;
          end
        end
        stall_prev = m_tvalid && !m_tready;
        stall_data = m_tdata;
        stall_last = m_tlast;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Entered and left at posedge+1
  task automatic send_word(input logic [DW-1:0] d, input logic l, input int gap_pct);
    int t = 0;
    while ($urandom_range(99) < gap_pct) begin
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      if (++t > 20000) abort_run("input_accept");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model: N dummies, the length word, then the first min(k,L) payload words, the last one tagged.
  task automatic send_packet(input int cfg, input int nhdr, input int len, input int k,
                             input int gap_pct);
    logic [DW-1:0] pay[$];
    int n = (cfg == 0) ? 10 : cfg;
    int nout = (k < len) ? k : len;
    for (int i = 0; i < n; i++) exp_q.push_back('{DUMMY, 1'b0});
    exp_q.push_back('{DW'(len), len == 0});
    for (int i = 0; i < k; i++) begin
      pay.push_back(rand_word());
      if (i < nout) exp_q.push_back('{pay[i], i == nout - 1});
    end
    if (len > 0 && k != len) err_model = 1'b1;
    cfg_hdr_n = 16'(cfg);
    for (int i = 0; i < nhdr; i++) send_word({8'h01, rand_word()[119:0]}, 1'b0, gap_pct);
    send_word(DW'(len), len == 0, gap_pct);
    for (int i = 0; i < k; i++) send_word(pay[i], i == k - 1, gap_pct);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      if (++t > 20000) abort_run("output_drain");
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_s_tready"}, DW'(s_tready), DW'(0));
    check({tag, "_m_tvalid"}, DW'(m_tvalid), DW'(0));
    check({tag, "_m_tlast"}, DW'(m_tlast), DW'(0));
    check({tag, "_m_tdata"}, m_tdata, DW'(0));
    check({tag, "_pkt_cnt"}, DW'(pkt_cnt), DW'(0));
    check({tag, "_err_len"}, DW'(err_len), DW'(0));
  endtask

  initial begin
    int len, k, r;
    rst_n = 1'b0;
    cfg_hdr_n = 16'd0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Default header count, tagged input headers, length 5
    clear_log();
    send_packet(0, 3, 5, 5, 0);
    wait_quiet();
    check("t1_beats", DW'(log_data.size()), DW'(16));
    check("t1_dummy0", log_data[0], 128'h0100_0000_0000_0000_0000_0000_0000_0000);
    check("t1_len", log_data[10], DW'(5));
    check("t1_last14", DW'(log_last[14]), DW'(0));
    check("t1_last15", DW'(log_last[15]), DW'(1));
    check("t1_cnt", DW'(pkt_cnt), DW'(1));
    check("t1_err", DW'(err_len), DW'(0));

    // Two headers, zero length
    clear_log();
    send_packet(2, 0, 0, 0, 0);
    wait_quiet();
    check("t2_beats", DW'(log_data.size()), DW'(3));
    check("t2_len", log_data[2], DW'(0));
    check("t2_last", DW'(log_last[2]), DW'(1));
    check("t2_cnt", DW'(pkt_cnt), DW'(2));

    // Early input TLAST truncates
    clear_log();
    send_packet(1, 1, 4, 2, 0);
    wait_quiet();
    check("t3_beats", DW'(log_data.size()), DW'(4));
    check("t3_last", DW'(log_last[3]), DW'(1));
    check("t3_err", DW'(err_len), DW'(1));
    clear_log();
    send_packet(1, 0, 3, 3, 0);
    wait_quiet();
    check("t3_good_beats", DW'(log_data.size()), DW'(5));

    // Excess tail is drained
    clear_log();
    send_packet(1, 0, 2, 5, 0);
    wait_quiet();
    check("t4_beats", DW'(log_data.size()), DW'(4));
    check("t4_last", DW'(log_last[3]), DW'(1));
    check("t4_cnt", DW'(pkt_cnt), DW'(5));

    // Throughput with both sides always ready
    clear_log();
    send_packet(1, 0, 200, 200, 0);
    wait_quiet();
    check("tput_beats", DW'(log_data.size()), DW'(202));
    check("tput_cycles", DW'(log_cyc[201] - log_cyc[2]), DW'(199));

    // Long packet under heavy output backpressure and input gaps
    ready_pct = 20;
    send_packet(3, 2, 200, 200, 30);
    wait_quiet();

    // Random packet mix
    for (int p = 0; p < 25; p++) begin
      ready_pct = $urandom_range(20, 100);
      len = $urandom_range(0, 12);
      r = $urandom_range(0, 9);
      if (len == 0) k = 0;
      else if (r < 6) k = len;
      else if (r < 8) k = $urandom_range(1, len);
      else k = len + $urandom_range(1, 3);
      send_packet($urandom_range(0, 4), $urandom_range(0, 3), len, k, $urandom_range(0, 40));
    end
    wait_quiet();
    check("rand_err", DW'(err_len), DW'(err_model));

    // Reset in the middle of a payload
    ready_pct = 100;
    mon_en = 1'b0;
    cfg_hdr_n = 16'd1;
    send_word(DW'(6), 1'b0, 0);
    for (int i = 0; i < 3; i++) send_word(rand_word(), 1'b0, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    @(posedge clk);
    #1;
    exp_q.delete();
    clear_log();
    cnt_model = 0;
    err_model = 1'b0;
    mon_en = 1'b1;
    send_packet(3, 1, 2, 2, 0);
    wait_quiet();
    check("rst_beats", DW'(log_data.size()), DW'(6));
    check("rst_dummy2", log_data[2], DUMMY);
    check("rst_len", log_data[3], DW'(2));
    check("rst_cnt", DW'(pkt_cnt), DW'(1));
    check("rst_err", DW'(err_len), DW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
